neo_zmc2: RTL and testbench

NEO_ZMC2 -- requirements
Module: neo_zmc2

---
 rtl/neo_zmc2_pkg.sv | 22 ++
 rtl/neo_zmc2_plane.sv | 35 +++
 rtl/neo_zmc2.sv | 49 ++++
 tb/tb_neo_zmc2.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/neo_zmc2_pkg.sv
// Shared widths and types for the NEO_ZMC2 sprite pixel serializer.
// Optional DOTA/DOTB generation is enabled by defining NEO_ZMC2_DOT_EN.
package neo_zmc2_pkg;

    localparam int PLANE_W     = 8;
    localparam int PLANES      = 4;
    localparam int PIX_W       = 4;
    localparam int PIX_PER_CLK = 2;

    typedef logic [PLANE_W-1:0]      plane_t;
    typedef plane_t [PLANES-1:0]     plane_arr_t;
    typedef logic [PIX_W-1:0]        pix_t;

    // One shift step moves each plane by one clock's worth of pixels.
    function automatic plane_t plane_shift(input plane_t v, input logic flip);
        plane_t r;
        if (flip) r = {v[PLANE_W-PIX_PER_CLK-1:0], {PIX_PER_CLK{1'b0}}};
        else      r = {{PIX_PER_CLK{1'b0}}, v[PLANE_W-1:PIX_PER_CLK]};
        return r;
    endfunction

endpackage

// File: rtl/neo_zmc2_plane.sv
// One bit-plane of the serializer: 8-bit load / bidirectional 2-bit shifter
// with the pixel A/B taps selected by the flip direction.
module neo_zmc2_plane
    import neo_zmc2_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   h,
    input  plane_t cr_plane,
    output logic   tap_a,
    output logic   tap_b
);

    plane_t sr_q;
    plane_t sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) sr_d = cr_plane;
        else      sr_d = plane_shift(sr_q, h);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr_q <= '0;
        else        sr_q <= sr_d;
    end

    // Taps follow H combinationally so a mid-word flip is visible at once.
    always_comb begin
        tap_a = h ? sr_q[PLANE_W-1] : sr_q[0];
        tap_b = h ? sr_q[PLANE_W-2] : sr_q[1];
    end

endmodule

// File: rtl/neo_zmc2.sv
// NEO_ZMC2 top: four plane shifters emitting two 4-bit pixels per clock.
// Define NEO_ZMC2_DOT_EN to generate DOTA/DOTB; otherwise they are tied low.
module neo_zmc2
    import neo_zmc2_pkg::*;
(
    input  logic        CLK_12M,
    input  logic        nRESET,
    input  logic        EVEN,
    input  logic        LOAD,
    input  logic        H,
    input  logic [31:0] CR,
    output logic [3:0]  GAD,
    output logic [3:0]  GBD,
    output logic        DOTA,
    output logic        DOTB
);

    plane_arr_t cr_planes;
    pix_t       pix_a;
    pix_t       pix_b;

    assign cr_planes = CR;

    for (genvar i = 0; i < PLANES; i++) begin : g_plane
        neo_zmc2_plane u_plane (
            .clk      (CLK_12M),
            .rst_n    (nRESET),
            .load     (LOAD),
            .h        (H),
            .cr_plane (cr_planes[i]),
            .tap_a    (pix_a[i]),
            .tap_b    (pix_b[i])
        );
    end

    always_comb begin
        GAD = EVEN ? pix_a : pix_b;
        GBD = EVEN ? pix_b : pix_a;
    end

`ifdef NEO_ZMC2_DOT_EN
    assign DOTA = |GAD;
    assign DOTB = |GBD;
`else
    assign DOTA = 1'b0;
    assign DOTB = 1'b0;
`endif

endmodule

// File: tb/tb_neo_zmc2.sv
// Directed self-checking bench for neo_zmc2 (both NEO_ZMC2_DOT_EN builds).
module tb_neo_zmc2;

    logic        clk;
    logic        rst_n;
    logic        even;
    logic        load;
    logic        h;
    logic [31:0] cr;
    logic [3:0]  gad;
    logic [3:0]  gbd;
    logic        dota;
    logic        dotb;

    int checks = 0;
    int errors = 0;

`ifdef NEO_ZMC2_DOT_EN
    localparam bit DOT_EN = 1'b1;
`else
    localparam bit DOT_EN = 1'b0;
`endif

    neo_zmc2 dut (
        .CLK_12M (clk),
        .nRESET  (rst_n),
        .EVEN    (even),
        .LOAD    (load),
        .H       (h),
        .CR      (cr),
        .GAD     (gad),
        .GBD     (gbd),
        .DOTA    (dota),
        .DOTB    (dotb)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_dot(input logic [3:0] c);
        return DOT_EN && (c != 4'd0);
    endfunction

    // driver: present a word with LOAD for one edge, leave 1 time unit after it
    task automatic load_word(input logic [31:0] w, input logic hv, input logic ev);
        cr   = w;
        h    = hv;
        even = ev;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        h     = 1'b0;
        even  = 1'b1;
        cr    = 32'hFFFF_FFFF;
        #1;
        checks++;
        if ({gad, gbd, dota, dotb} !== 10'd0) begin
            errors++;
            $display("FAIL reset_low: GAD=%0d GBD=%0d DOTA=%0d DOTB=%0d, expected all 0", gad, gbd, dota, dotb);
        end
        load = 1'b1;
        @(posedge clk);
        #1;
        load  = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({gad, gbd, dota, dotb} !== 10'd0) begin
            errors++;
            $display("FAIL reset_release: GAD=%0d GBD=%0d DOTA=%0d DOTB=%0d, expected all 0", gad, gbd, dota, dotb);
        end
    endtask

    task automatic test_h0_even1();
        logic [3:0] ea [0:4];
        logic [3:0] eb [0:4];
        ea = '{4'd7, 4'd5, 4'd3, 4'd1, 4'd0};
        eb = '{4'd6, 4'd4, 4'd2, 4'd0, 4'd0};
        load_word(32'h000F_3355, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            checks++;
            if ({gad, gbd, dota, dotb} !== {ea[i], eb[i], exp_dot(ea[i]), exp_dot(eb[i])}) begin
                errors++;
                $display("FAIL h0_even1 pair%0d: GAD=%0d GBD=%0d DOTA=%0d DOTB=%0d, expected %0d %0d %0d %0d",
                         i, gad, gbd, dota, dotb, ea[i], eb[i], exp_dot(ea[i]), exp_dot(eb[i]));
            end
        end
    endtask

    task automatic test_h1_even1();
        logic [3:0] ea [0:4];
        logic [3:0] eb [0:4];
        ea = '{4'd0, 4'd2, 4'd4, 4'd6, 4'd0};
        eb = '{4'd1, 4'd3, 4'd5, 4'd7, 4'd0};
        load_word(32'h000F_3355, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            checks++;
            if ({gad, gbd, dota, dotb} !== {ea[i], eb[i], exp_dot(ea[i]), exp_dot(eb[i])}) begin
                errors++;
                $display("FAIL h1_even1 pair%0d: GAD=%0d GBD=%0d DOTA=%0d DOTB=%0d, expected %0d %0d %0d %0d",
                         i, gad, gbd, dota, dotb, ea[i], eb[i], exp_dot(ea[i]), exp_dot(eb[i]));
            end
        end
    endtask

    task automatic test_h0_even0();
        logic [3:0] ea [0:4];
        logic [3:0] eb [0:4];
        ea = '{4'd6, 4'd4, 4'd2, 4'd0, 4'd0};
        eb = '{4'd7, 4'd5, 4'd3, 4'd1, 4'd0};
        load_word(32'h000F_3355, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            checks++;
            if ({gad, gbd, dota, dotb} !== {ea[i], eb[i], exp_dot(ea[i]), exp_dot(eb[i])}) begin
                errors++;
                $display("FAIL h0_even0 pair%0d: GAD=%0d GBD=%0d DOTA=%0d DOTB=%0d, expected %0d %0d %0d %0d",
                         i, gad, gbd, dota, dotb, ea[i], eb[i], exp_dot(ea[i]), exp_dot(eb[i]));
            end
        end
    endtask

    // H flipped after the load edge: taps change at once, next shift goes left
    task automatic test_hflip_midword();
        load_word(32'h000F_3355, 1'b0, 1'b1);
        checks++;
        if ({gad, gbd} !== {4'd7, 4'd6}) begin
            errors++;
            $display("FAIL hflip_before: GAD=%0d GBD=%0d, expected 7 6", gad, gbd);
        end
        h = 1'b1;
        #1;
        checks++;
        if ({gad, gbd} !== {4'd0, 4'd1}) begin
            errors++;
            $display("FAIL hflip_same_cycle: GAD=%0d GBD=%0d, expected 0 1", gad, gbd);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({gad, gbd} !== {4'd2, 4'd3}) begin
            errors++;
            $display("FAIL hflip_shift_left: GAD=%0d GBD=%0d, expected 2 3", gad, gbd);
        end
        h = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midword();
        load_word(32'hFFFF_FFFF, 1'b0, 1'b1);
        checks++;
        if ({gad, gbd, dota, dotb} !== {4'd15, 4'd15, DOT_EN, DOT_EN}) begin
            errors++;
            $display("FAIL rst_mid_loaded: GAD=%0d GBD=%0d DOTA=%0d DOTB=%0d, expected 15 15 %0d %0d",
                     gad, gbd, dota, dotb, DOT_EN, DOT_EN);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gad, gbd, dota, dotb} !== 10'd0) begin
            errors++;
            $display("FAIL rst_mid_async: GAD=%0d GBD=%0d DOTA=%0d DOTB=%0d, expected all 0", gad, gbd, dota, dotb);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({gad, gbd, dota, dotb} !== 10'd0) begin
                errors++;
                $display("FAIL rst_mid_after%0d: GAD=%0d GBD=%0d DOTA=%0d DOTB=%0d, expected all 0",
                         i, gad, gbd, dota, dotb);
            end
        end
        load_word(32'h0000_00F0, 1'b1, 1'b1);
        checks++;
        if ({gad, gbd} !== {4'd1, 4'd1}) begin
            errors++;
            $display("FAIL rst_first_load: GAD=%0d GBD=%0d, expected 1 1", gad, gbd);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [3:0] e [0:6];
        e = '{4'd1, 4'd1, 4'd8, 4'd8, 4'd8, 4'd8, 4'd0};
        load_word(32'h0000_00FF, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            if (i == 2) load_word(32'hFF00_0000, 1'b0, 1'b1);
            else if (i > 0) begin @(posedge clk); #1; end
            checks++;
            if ({gad, gbd, dota, dotb} !== {e[i], e[i], exp_dot(e[i]), exp_dot(e[i])}) begin
                errors++;
                $display("FAIL back_to_back step%0d: GAD=%0d GBD=%0d DOTA=%0d DOTB=%0d, expected %0d %0d %0d %0d",
                         i, gad, gbd, dota, dotb, e[i], e[i], exp_dot(e[i]), exp_dot(e[i]));
            end
        end
        // Consecutive LOAD edges: each reload restarts the word.
        load_word(32'h0000_00FF, 1'b0, 1'b1);
        load_word(32'h0F00_0000, 1'b0, 1'b1);
        checks++;
        if ({gad, gbd} !== {4'd8, 4'd8}) begin
            errors++;
            $display("FAIL reload_consecutive: GAD=%0d GBD=%0d, expected 8 8", gad, gbd);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({gad, gbd} !== {4'd0, 4'd0}) begin
            errors++;
            $display("FAIL reload_drained: GAD=%0d GBD=%0d, expected 0 0", gad, gbd);
        end
    endtask

    initial begin
        test_reset();
        test_h0_even1();
        test_h1_even1();
        test_h0_even0();
        test_hflip_midword();
        test_reset_midword();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
